booth_r4_seq_multiplier: RTL and testbench



---
 rtl/booth_pkg.sv | 37 +++
 rtl/booth_r4_recoder.sv | 19 +
 rtl/booth_r4_seq_multiplier.sv | 145 ++++++++++++++
 tb/tb_booth_r4_seq_multiplier.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multipliers: controller states and the
// digit encoding that the recoder produces.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A Booth digit in {0,+1,+2,-1,-2}: magnitude select (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
  localparam booth_digit_t DIGIT_P1   = '{neg: 1'b0, one: 1'b1, two: 1'b0};
  localparam booth_digit_t DIGIT_P2   = '{neg: 1'b0, one: 1'b0, two: 1'b1};
  localparam booth_digit_t DIGIT_M1   = '{neg: 1'b1, one: 1'b1, two: 1'b0};
  localparam booth_digit_t DIGIT_M2   = '{neg: 1'b1, one: 1'b0, two: 1'b1};

  // Zero digits keep neg low so no stray carry-in reaches the adder.
  function automatic booth_digit_t booth_recode(input logic [2:0] window);
    booth_digit_t d;
    case (window)
      3'b001, 3'b010: d = DIGIT_P1;
      3'b011:         d = DIGIT_P2;
      3'b100:         d = DIGIT_M2;
      3'b101, 3'b110: d = DIGIT_M1;
      default:        d = DIGIT_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier window to a digit.
// Shared with the partial-product generator of the combinational array.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       one,
  output logic       two
);

  booth_digit_t digit;

  assign digit = booth_recode(window);
  assign neg   = digit.neg;
  assign one   = digit.one;
  assign two   = digit.two;

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Iterative radix-4 Booth signed multiplier. One shared WIDTH+2 bit ripple
// adder is reused for WIDTH/2 iterations; valid/ready on both sides plus a
// synchronous abort.
module booth_r4_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 2 + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
);

  // Two guard bits so that +/-2A of a full-scale operand cannot overflow.
  localparam int AW = WIDTH + 2;

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $fatal(1, "booth_r4_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_t               state;
  state_t               state_nxt;
  logic                 load;
  logic                 step;

  logic [CNT_W-1:0]     count;
  logic [2*WIDTH+1:0]   acc;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH:0]       mreg;

  logic                 d_neg;
  logic                 d_one;
  logic                 d_two;

  logic [AW-1:0]        a_ext;
  logic [AW-1:0]        mag;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        carry;

  booth_r4_recoder u_recoder (
    .window (mreg[2:0]),
    .neg    (d_neg),
    .one    (d_one),
    .two    (d_two)
  );

  assign a_ext = {{2{a_reg[WIDTH-1]}}, a_reg};

  // Select d*A magnitude; negation is one's complement with carry-in below.
  always_comb begin
    mag = '0;
    if (d_two) begin
      mag = {a_ext[AW-2:0], 1'b0};
    end else if (d_one) begin
      mag = a_ext;
    end
    addend = d_neg ? ~mag : mag;
  end

  assign carry[0] = d_neg;

  // Ripple of full-adder cells over the upper half of the accumulator.
  for (genvar i = 0; i < AW; i++) begin : g_fa
    assign sum[i] = acc[WIDTH+i] ^ addend[i] ^ carry[i];
    if (i < AW - 1) begin : g_carry
      assign carry[i+1] = (acc[WIDTH+i] & addend[i]) |
                          (carry[i] & (acc[WIDTH+i] ^ addend[i]));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; abort overrides both handshakes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = CALC;
          end
        end
        CALC: begin
          step = 1'b1;
          if (count == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture and one Booth iteration per CALC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      a_reg <= '0;
      mreg  <= '0;
    end else if (load) begin
      count <= CNT_W'(WIDTH / 2);
      acc   <= '0;
      a_reg <= in_a;
      mreg  <= {in_b, 1'b0};
    end else if (step) begin
      count <= count - CNT_W'(1);
      acc   <= {{2{sum[AW-1]}}, sum, acc[WIDTH-1:2]};
      mreg  <= mreg >> 2;
    end
  end

  assign in_ready    = (state == IDLE);
  assign busy        = (state == CALC);
  assign out_valid   = (state == DONE);
  assign out_product = acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Directed bench for the sequential radix-4 Booth multiplier: WIDTH=8 main
// instance, WIDTH=4 for an exhaustive sweep, WIDTH=16 for back-to-back runs.
module tb_booth_r4_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid = 0, in_ready, abort = 0, busy, out_valid, out_ready = 0;
  logic [7:0]  in_a = 0, in_b = 0;
  logic [15:0] out_product;

  logic        v4_in_valid = 0, v4_in_ready, v4_busy, v4_out_valid, v4_out_ready = 1;
  logic [3:0]  v4_in_a = 0, v4_in_b = 0;
  logic [7:0]  v4_out_product;

  logic        w16_in_valid = 0, w16_in_ready, w16_busy, w16_out_valid, w16_out_ready = 1;
  logic [15:0] w16_in_a = 0, w16_in_b = 0;
  logic [31:0] w16_out_product;

  booth_r4_seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .abort(abort), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product)
  );

  booth_r4_seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .in_a(v4_in_a), .in_b(v4_in_b), .abort(1'b0), .busy(v4_busy),
    .out_valid(v4_out_valid), .out_ready(v4_out_ready), .out_product(v4_out_product)
  );

  booth_r4_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
    .in_a(w16_in_a), .in_b(w16_in_b), .abort(1'b0), .busy(w16_busy),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready), .out_product(w16_out_product)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1;
    step();
    in_valid = 0;
    in_a = 8'hA5;
    in_b = 8'h3C;
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
    int lat;
    out_ready = 1;
    accept8(a, b);
    vec_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s accept: busy=%b in_ready=%b expected busy=1 in_ready=0", name, busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    vec_cnt++;
    if (lat !== 4) begin
      err_cnt++;
      $display("FAIL %s latency: got %0d edges expected 4", name, lat);
    end
    vec_cnt++;
    if (out_product !== exp) begin
      err_cnt++;
      $display("FAIL %s product: got %h expected %h", name, out_product, exp);
    end
    step();
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s release: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    step();
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_product !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset: in_ready=%b busy=%b out_valid=%b product=%h expected 1/0/0/0000",
               in_ready, busy, out_valid, out_product);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    run_op8(8'd3, 8'hFB, 16'hFFF1, "3x-5");
  endtask

  task automatic test_corners();
    run_op8(8'h80, 8'h80, 16'h4000, "-128x-128");
    run_op8(8'h7F, 8'h80, 16'hC080, "127x-128");
    run_op8(8'h00, 8'h5A, 16'h0000, "0x5A");
    run_op8(8'hFF, 8'hFF, 16'h0001, "-1x-1");
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    accept8(8'd7, 8'd9);
    repeat (4) step();
    in_valid = 1;
    in_a = 8'd2;
    in_b = 8'd2;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (out_valid !== 1'b1 || out_product !== 16'h003F || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold cycle %0d: out_valid=%b product=%h in_ready=%b expected 1/003F/0",
                 i, out_valid, out_product, in_ready);
      end
      step();
    end
    in_valid = 0;
    out_ready = 1;
    step();
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL hold release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    bit seen;
    out_ready = 1;
    accept8(8'd100, 8'd100);
    step();
    abort = 1;
    step();
    abort = 0;
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort calc: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen = 1;
      step();
    end
    vec_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort result: out_valid rose got 1 expected 0");
    end
    run_op8(8'd2, 8'd3, 16'h0006, "2x3 after abort");

    abort = 1;
    in_valid = 1;
    in_a = 8'd9;
    in_b = 8'd9;
    step();
    in_valid = 0;
    abort = 0;
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end

    out_ready = 0;
    accept8(8'd1, 8'd1);
    repeat (4) step();
    abort = 1;
    step();
    abort = 0;
    out_ready = 1;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort done: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1;
    accept8(8'd5, 8'd6);
    step();
    #2;
    rst_n = 0;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_product !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset mid: in_ready=%b busy=%b out_valid=%b product=%h expected 1/0/0/0000",
               in_ready, busy, out_valid, out_product);
    end
    step();
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1;
    end
    vec_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset mid result: activity after release got 1 expected 0");
    end
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [7:0] exp;
    v4_out_ready = 1;
    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        exp = 8'(ai * bi);
        v4_in_a = 4'(ai);
        v4_in_b = 4'(bi);
        v4_in_valid = 1;
        step();
        v4_in_valid = 0;
        lat = 0;
        while (v4_out_valid !== 1'b1 && lat < 8) begin
          step();
          lat++;
        end
        vec_cnt++;
        if (lat !== 2 || v4_out_product !== exp) begin
          err_cnt++;
          $display("FAIL w4 %0d*%0d: got %h after %0d edges expected %h after 2",
                   ai, bi, v4_out_product, lat, exp);
        end
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_acc;
    int guard;
    logic [15:0] a, b;
    logic [31:0] exp;
    w16_out_ready = 1;
    last_acc = -1;
    for (int n = 0; n < 20; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (n == 0) begin a = 16'h8000; b = 16'h8000; end
      if (n == 1) begin a = 16'h7FFF; b = 16'h8000; end
      exp = 32'($signed(a)) * 32'($signed(b));
      w16_in_a = a;
      w16_in_b = b;
      w16_in_valid = 1;
      guard = 0;
      while (w16_in_ready !== 1'b1 && guard < 20) begin
        step();
        guard++;
      end
      step();
      w16_in_valid = 0;
      if (last_acc >= 0) begin
        vec_cnt++;
        if (cyc - last_acc !== 10) begin
          err_cnt++;
          $display("FAIL w16 interval %0d: got %0d cycles expected 10", n, cyc - last_acc);
        end
      end
      last_acc = cyc;
      guard = 0;
      while (w16_out_valid !== 1'b1 && guard < 20) begin
        step();
        guard++;
      end
      vec_cnt++;
      if (w16_out_product !== exp) begin
        err_cnt++;
        $display("FAIL w16 %h*%h: got %h expected %h", a, b, w16_out_product, exp);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_exhaustive4();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
